// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core types: FSM state codes, operand-forward select codes, E/W shadow records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_FLUSH      = 2'b10
    } state_e;

    // Operand source select, also consumed by the execute-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_e;

    // What the execute stage currently holds, as far as hazards are concerned.
    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
        logic     ld;
    } e_shadow_t;

    // Writeback stage only matters as a forwarding source.
    typedef struct packed {
        reg_idx_t rd;
        logic     wr;
    } w_shadow_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute hazard bus between the pipeline and the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: stall_f/bubble_e/flush_d flow back to the pipeline on this bus.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             d_valid;
    reg_idx_t         d_rs1;
    reg_idx_t         d_rs2;
    reg_idx_t         d_rd;
    logic             d_writesRd;
    logic             d_usesRs2;
    logic             d_isLoad;
    logic             e_taken;

    logic             stall_f;
    logic             bubble_e;
    logic             flush_d;
    logic [1:0]       fwd_rs1;
    logic [1:0]       fwd_rs2;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: presents decode/execute info, obeys the controls.
    modport master (
        output d_valid, d_rs1, d_rs2, d_rd, d_writesRd, d_usesRs2, d_isLoad, e_taken,
        input  stall_f, bubble_e, flush_d, fwd_rs1, fwd_rs2, state, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  d_valid, d_rs1, d_rs2, d_rd, d_writesRd, d_usesRs2, d_isLoad, e_taken,
        output stall_f, bubble_e, flush_d, fwd_rs1, fwd_rs2, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Compares one decode source against the E/W shadows: forward select plus load-use flag.
// Latency: combinational.
// Backpressure: none; load_use is the raw request, the controller decides whether to stall.
module hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic      live,
    input  reg_idx_t  src,
    input  e_shadow_t e_sh,
    input  w_shadow_t w_sh,
    output fwd_e      fwd,
    output logic      load_use
);

    // Youngest producer wins; a load in E cannot forward yet, so it flags instead.
    always_comb begin
        fwd      = FWD_RF;
        load_use = 1'b0;
        if (live && e_sh.wr && (src == e_sh.rd)) begin
            if (e_sh.ld) begin
                load_use = 1'b1;
            end else begin
                fwd = FWD_EX;
            end
        end
        if ((fwd == FWD_RF) && live && w_sh.wr && (src == w_sh.rd)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch flush and operand-forward control for a 5-stage pipe.
// Latency: controls are combinational from decode inputs; state/counters update on clk.
// Backpressure: stall_f holds fetch/decode one cycle per load-use; flush_d squashes FLUSH_CYCLES slots.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]       rst_sync_q;
    logic             active;
    state_e           state_q;
    logic [1:0]       fl_cnt_q;
    e_shadow_t        e_q;
    w_shadow_t        w_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             live1;
    logic             live2;
    fwd_e             fwd1;
    fwd_e             fwd2;
    logic             lu1;
    logic             lu2;
    logic             taken;
    logic             stall_c;
    logic             flush_c;
    logic             bubble_c;

    // Reset asserts immediately but releases two edges later, so the first live edge sees RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign active = rst_sync_q[1];

    // x0 and absent instructions never take part in hazards.
    assign live1 = bus.d_valid && (bus.d_rs1 != '0);
    assign live2 = bus.d_valid && bus.d_usesRs2 && (bus.d_rs2 != '0);

    hazard_cmp u_cmp_rs1 (
        .live     (live1),
        .src      (bus.d_rs1),
        .e_sh     (e_q),
        .w_sh     (w_q),
        .fwd      (fwd1),
        .load_use (lu1)
    );

    hazard_cmp u_cmp_rs2 (
        .live     (live2),
        .src      (bus.d_rs2),
        .e_sh     (e_q),
        .w_sh     (w_q),
        .fwd      (fwd2),
        .load_use (lu2)
    );

    // A taken branch overrides everything; load-use is only honoured from RUN.
    assign taken    = active && bus.e_taken;
    assign flush_c  = taken || (active && (state_q == ST_FLUSH) && (fl_cnt_q != 2'd0));
    assign stall_c  = active && !taken && (state_q == ST_RUN) && (lu1 || lu2);
    assign bubble_c = flush_c || stall_c;

    assign bus.stall_f   = stall_c;
    assign bus.bubble_e  = bubble_c;
    assign bus.flush_d   = flush_c;
    assign bus.fwd_rs1   = active ? fwd1 : FWD_RF;
    assign bus.fwd_rs2   = active ? fwd2 : FWD_RF;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // Control FSM: RUN / one-cycle LOAD_STALL / FLUSH countdown (skipped when FLUSH_CYCLES=1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            fl_cnt_q <= 2'd0;
        end else if (!active) begin
            state_q  <= ST_RUN;
            fl_cnt_q <= 2'd0;
        end else if (taken) begin
            fl_cnt_q <= FL_LOAD;
            state_q  <= (FL_LOAD == 2'd0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stall_c) state_q <= ST_LOAD_STALL;
                end
                ST_LOAD_STALL: begin
                    state_q <= ST_RUN;
                end
                ST_FLUSH: begin
                    if (fl_cnt_q <= 2'd1) state_q <= ST_RUN;
                    if (fl_cnt_q != 2'd0) fl_cnt_q <= fl_cnt_q - 2'd1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // E follows decode unless a bubble is inserted; W always follows E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            w_q <= '0;
        end else if (!active) begin
            e_q <= '0;
            w_q <= '0;
        end else begin
            if (bubble_c || !bus.d_valid) begin
                e_q <= '0;
            end else begin
                e_q <= '{rd: bus.d_rd, wr: bus.d_writesRd, ld: bus.d_isLoad};
            end
            w_q <= '{rd: e_q.rd, wr: e_q.wr};
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (taken && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: FLUSH_CYCLES=2 and FLUSH_CYCLES=1 instances share stimulus; directed table + random vs model.
// Latency: outputs sampled 1 time unit after the falling edge that drives inputs.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic       us2;
        logic       ld;
        logic       taken;
    } in_t;

    typedef struct packed {
        logic          stall;
        logic          bubble;
        logic          flush;
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    // Instruction-level view of the pipe: what sits in EX and WB, plus pending squash slots.
    typedef struct {
        logic [4:0] ex_rd;
        bit         ex_wr;
        bit         ex_ld;
        logic [4:0] wb_rd;
        bit         wb_wr;
        int         flush_left;
        bit         stalled_last;
        int         scnt;
        int         fcnt;
    } model_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    model_t m0;
    model_t m1;
    vec_t   tab[17];

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus1 ();

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(CW)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(bit v, int r1, int r2, int rd, bit wr, bit u2, bit ld, bit tk);
        in_t i;
        i.valid = v; i.rs1 = 5'(r1); i.rs2 = 5'(r2); i.rd = 5'(rd);
        i.wr = wr; i.us2 = u2; i.ld = ld; i.taken = tk;
        return i;
    endfunction

    function automatic out_t mo(bit s, bit b, bit f, int f1, int f2, int st, int sc, int fc);
        out_t o;
        o.stall = s; o.bubble = b; o.flush = f;
        o.f1 = 2'(f1); o.f2 = 2'(f2); o.st = 2'(st); o.sc = CW'(sc); o.fc = CW'(fc);
        return o;
    endfunction

    function automatic logic [1:0] fwd_of(model_t m, logic [4:0] s, bit live);
        if (!live || s == 5'd0) return 2'b00;
        if (m.ex_wr && !m.ex_ld && s == m.ex_rd) return 2'b01;
        if (m.wb_wr && s == m.wb_rd) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit loads_into(model_t m, logic [4:0] s, bit live);
        return live && s != 5'd0 && m.ex_wr && m.ex_ld && s == m.ex_rd;
    endfunction

    function automatic out_t model_out(model_t m, in_t i);
        out_t o;
        bit   lu;
        o    = '0;
        o.f1 = fwd_of(m, i.rs1, i.valid);
        o.f2 = fwd_of(m, i.rs2, i.valid && i.us2);
        lu   = loads_into(m, i.rs1, i.valid) || loads_into(m, i.rs2, i.valid && i.us2);
        o.st = (m.flush_left > 0) ? 2'b10 : (m.stalled_last ? 2'b01 : 2'b00);
        if (i.taken || m.flush_left > 0) begin
            o.flush  = 1'b1;
            o.bubble = 1'b1;
        end else if (!m.stalled_last && lu) begin
            o.stall  = 1'b1;
            o.bubble = 1'b1;
        end
        o.sc = CW'(m.scnt);
        o.fc = CW'(m.fcnt);
        return o;
    endfunction

    function automatic model_t model_next(model_t m, in_t i, int fcyc);
        out_t   o;
        model_t n;
        o = model_out(m, i);
        n = m;
        if (o.stall && n.scnt < MAX) n.scnt = n.scnt + 1;
        if (i.taken) begin
            if (n.fcnt < MAX) n.fcnt = n.fcnt + 1;
            n.flush_left = fcyc - 1;
        end else if (m.flush_left > 0) begin
            n.flush_left = m.flush_left - 1;
        end
        n.stalled_last = o.stall;
        n.wb_rd = m.ex_rd;
        n.wb_wr = m.ex_wr;
        if (o.bubble || !i.valid) begin
            n.ex_rd = 5'd0; n.ex_wr = 1'b0; n.ex_ld = 1'b0;
        end else begin
            n.ex_rd = i.rd; n.ex_wr = i.wr; n.ex_ld = i.ld;
        end
        return n;
    endfunction

    function automatic out_t get0();
        out_t o;
        o.stall = bus0.stall_f; o.bubble = bus0.bubble_e; o.flush = bus0.flush_d;
        o.f1 = bus0.fwd_rs1; o.f2 = bus0.fwd_rs2; o.st = bus0.state;
        o.sc = bus0.stall_cnt; o.fc = bus0.flush_cnt;
        return o;
    endfunction

    function automatic out_t get1();
        out_t o;
        o.stall = bus1.stall_f; o.bubble = bus1.bubble_e; o.flush = bus1.flush_d;
        o.f1 = bus1.fwd_rs1; o.f2 = bus1.fwd_rs2; o.st = bus1.state;
        o.sc = bus1.stall_cnt; o.fc = bus1.flush_cnt;
        return o;
    endfunction

    task automatic drive(input in_t v);
        bus0.d_valid = v.valid; bus0.d_rs1 = v.rs1; bus0.d_rs2 = v.rs2; bus0.d_rd = v.rd;
        bus0.d_writesRd = v.wr; bus0.d_usesRs2 = v.us2; bus0.d_isLoad = v.ld; bus0.e_taken = v.taken;
        bus1.d_valid = v.valid; bus1.d_rs1 = v.rs1; bus1.d_rs2 = v.rs2; bus1.d_rd = v.rd;
        bus1.d_writesRd = v.wr; bus1.d_usesRs2 = v.us2; bus1.d_isLoad = v.ld; bus1.e_taken = v.taken;
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got stall=%b bubble=%b flush=%b fwd=%b/%b state=%b scnt=%0d fcnt=%0d, want stall=%b bubble=%b flush=%b fwd=%b/%b state=%b scnt=%0d fcnt=%0d",
                     name, got.stall, got.bubble, got.flush, got.f1, got.f2, got.st, got.sc, got.fc,
                     exp.stall, exp.bubble, exp.flush, exp.f1, exp.f2, exp.st, exp.sc, exp.fc);
        end
    endtask

    // One clock: drive on the falling edge, compare both DUTs to the model, advance the model.
    task automatic cycle(input in_t v, input string name, output out_t o0);
        out_t o1;
        @(negedge clk);
        drive(v);
        #1;
        o0 = get0();
        o1 = get1();
        check({name, "/fc2"}, o0, model_out(m0, v));
        check({name, "/fc1"}, o1, model_out(m1, v));
        m0 = model_next(m0, v, 2);
        m1 = model_next(m1, v, 1);
    endtask

    initial begin
        out_t o;
        in_t  idle;
        n_vec = 0;
        n_err = 0;
        m0    = '{default: 0};
        m1    = '{default: 0};
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0);

        //              valid rs1 rs2 rd wr u2 ld tk        stall bub fl f1 f2 st sc fc
        tab[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)};
        tab[1]  = '{mk(1, 1, 2, 5, 1, 1, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0)};
        tab[2]  = '{mk(1, 5, 0, 6, 1, 0, 0, 0), mo(0, 0, 0, 1, 0, 0, 0, 0)};
        tab[3]  = '{mk(1, 0, 5, 8, 1, 1, 0, 0), mo(0, 0, 0, 0, 2, 0, 0, 0)};
        tab[4]  = '{mk(1, 8, 0, 7, 1, 0, 1, 0), mo(0, 0, 0, 1, 0, 0, 0, 0)};
        tab[5]  = '{mk(1, 7, 0, 9, 1, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 0, 0)};
        tab[6]  = '{mk(1, 7, 0, 9, 1, 0, 0, 0), mo(0, 0, 0, 2, 0, 1, 1, 0)};
        tab[7]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0)};
        tab[8]  = '{mk(1, 0, 0, 3, 1, 1, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 0)};
        tab[9]  = '{mk(1, 3, 0, 0, 0, 0, 0, 1), mo(0, 1, 1, 0, 0, 0, 1, 0)};
        tab[10] = '{mk(1, 3, 0, 0, 0, 0, 0, 0), mo(0, 1, 1, 2, 0, 2, 1, 1)};
        tab[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 1)};
        tab[12] = '{mk(1, 0, 0, 4, 1, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 1)};
        tab[13] = '{mk(1, 4, 0, 0, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 1, 1)};
        tab[14] = '{mk(1, 4, 0, 0, 0, 0, 0, 1), mo(0, 1, 1, 2, 0, 1, 2, 1)};
        tab[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), mo(0, 1, 1, 0, 0, 2, 2, 2)};
        tab[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 2)};

        // Reset with hazard-looking inputs: every output must stay low.
        reset = 1'b0;
        drive(mk(1, 5, 5, 5, 1, 1, 1, 1));
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold/fc2", get0(), '0);
        check("reset_hold/fc1", get1(), '0);
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // Directed table on the FLUSH_CYCLES=2 instance.
        for (int i = 0; i < 17; i++) begin
            cycle(tab[i].in, $sformatf("tab%0d_model", i), o);
            check($sformatf("tab%0d", i), o, tab[i].exp);
        end

        // Drive stall_cnt into saturation and beyond.
        for (int k = 0; k < 16; k++) begin
            cycle(mk(1, 0, 0, 4, 1, 0, 1, 0), "sat_load", o);
            cycle(mk(1, 4, 0, 0, 0, 0, 0, 0), "sat_use", o);
            cycle(mk(1, 4, 0, 0, 0, 0, 0, 0), "sat_hold", o);
        end
        cycle(idle, "sat_idle", o);
        check("stall_cnt_saturated", o, mo(0, 0, 0, 0, 0, 0, MAX, 2));

        // Reset in the middle of a flush: outputs drop without waiting for a clock.
        cycle(mk(1, 0, 0, 5, 1, 0, 0, 0), "mid_wr", o);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 1), "mid_taken", o);
        cycle(mk(1, 5, 0, 0, 0, 0, 0, 0), "mid_flush", o);
        check("mid_flush_state", o, mo(0, 1, 1, 2, 0, 2, MAX, 3));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset/fc2", get0(), '0);
        check("async_reset/fc1", get1(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        m0 = '{default: 0};
        m1 = '{default: 0};
        repeat (3) @(posedge clk);
        cycle(mk(1, 5, 0, 0, 0, 0, 0, 0), "post_reset", o);
        check("post_reset_run", o, '0);

        // Random traffic over a small register set so hazards are frequent.
        for (int k = 0; k < 400; k++) begin
            in_t r;
            r.valid = ($urandom_range(0, 7) != 0);
            r.rs1   = 5'($urandom_range(0, 3));
            r.rs2   = 5'($urandom_range(0, 3));
            r.rd    = 5'($urandom_range(0, 3));
            r.wr    = 1'($urandom_range(0, 1));
            r.us2   = 1'($urandom_range(0, 1));
            r.ld    = ($urandom_range(0, 2) == 0);
            r.taken = ($urandom_range(0, 7) == 0);
            cycle(r, $sformatf("rnd%0d", k), o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 1, setting the number of decode slots squashed per taken branch (range 1-3).
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the width of the stall and flush event counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 d_valid  input  1  decode stage holds a real instruction.
REQ-006 d_rs1, d_rs2  input  5 each  decode-stage source register indices.
REQ-007 d_rd  input  5  decode-stage destination index.
REQ-008 d_writesRd, d_usesRs2, d_isLoad  input  1 each  decode-stage instruction attributes.
REQ-009 e_taken  input  1  execute stage resolved a taken branch this cycle.
REQ-010 stall_f  output  1  hold PC and decode register.
REQ-011 bubble_e  output  1  load a NOP into the execute register.
REQ-012 flush_d  output  1  squash the current decode instruction.
REQ-013 fwd_rs1, fwd_rs2  output  2 each  operand select: 00 register file, 01 execute result, 10 write-stage data.
REQ-014 state  output  2  FSM state: 00 RUN, 01 LOAD_STALL, 10 FLUSH.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 The block SHALL keep shadow registers for E (e_rd, e_wr, e_ld) and W (w_rd, w_wr), updated each cycle.
- E takes decode attributes when decode advances.
- E is cleared when bubble_e=1.
- W takes E unconditionally.
REQ-017 A source is live when it is nonzero, d_valid=1, and (rs1, or rs2 with d_usesRs2=1).
REQ-018 fwd_rsX SHALL be combinational and follow this order.
- 01 when the live source equals e_rd with e_wr=1 and e_ld=0.
- Otherwise 10 when it equals w_rd with w_wr=1.
- Otherwise 00.
REQ-019 In RUN, a live source equal to e_rd with e_wr=1 and e_ld=1 is a load-use hazard.
- stall_f=1 and bubble_e=1 in the same cycle.
- Next state is LOAD_STALL.
REQ-020 LOAD_STALL SHALL last exactly one cycle with stall_f=0, then return to RUN; the stalled instruction then forwards from W (10).
REQ-021 e_taken=1 in any state SHALL have priority over all other events.
- flush_d=1 and bubble_e=1 that cycle.
- Any pending load stall is dropped.
- Next state is FLUSH with a down-counter loaded to FLUSH_CYCLES-1.
REQ-022 In FLUSH, flush_d=1 and bubble_e=1 while the counter is nonzero; at zero, return to RUN with outputs deasserted.
REQ-023 With FLUSH_CYCLES=1, FLUSH SHALL occupy zero extra cycles, i.e. RUN directly.
REQ-024 stall_cnt SHALL increment on every cycle with stall_f=1.
REQ-025 flush_cnt SHALL increment once per e_taken event.
REQ-026 Both counters SHALL saturate at all-ones.
REQ-027 Register x0 SHALL never cause forwarding or a stall.
REQ-028 d_valid=0 SHALL suppress all hazards; E then receives a bubble.

Reset
REQ-029 While reset=0, asynchronously: state=RUN, all shadow registers 0, counters 0, FLUSH down-counter 0.
REQ-030 During reset all outputs SHALL be 0.
REQ-031 Reset release SHALL be synchronised so the first active edge is in RUN; reset mid-stall or mid-flush SHALL abandon the sequence.

Structure
REQ-032 State encodings and the fwd select codes (FWD_RF=00, FWD_EX=01, FWD_WB=10) SHALL live in the shared core package, for use by the execute stage.
REQ-033 One sub-module, hazard_cmp, SHALL compare one source against the E/W shadows and return its fwd code and a load-use flag; it is instantiated twice.

Verification
REQ-034 Back-to-back ALU ops: add x5 then use x5 as rs1 -> fwd_rs1=01, no stall.
REQ-035 Gap of one instruction: rs2=x5 with d_usesRs2=1 -> fwd_rs2=10.
REQ-036 Load x7 then use x7 -> stall_f=1 and bubble_e=1 for one cycle, state 01 then 00, stall_cnt=1, then fwd=10.
REQ-037 e_taken=1 during LOAD_STALL with FLUSH_CYCLES=2 -> flush_d=1 for 2 cycles, state 10, flush_cnt=1, then RUN.
REQ-038 rd=x0 writer followed by an x0 reader -> fwd=00, no stall; force stall_cnt to all-ones -> further stalls keep it all-ones.
REQ-039 Assert reset=0 mid-FLUSH -> all outputs 0 immediately (asynchronous), state=RUN after release.
